// File: rtl/frame_pkg.sv
// Shared types and constants for the frame pattern generator.
package frame_pkg;

  // Raster position counters are this wide.
  localparam int COORD_W = 16;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACTIVE = 2'd1,
    ST_HBLANK = 2'd2,
    ST_VBLANK = 2'd3
  } frame_state_e;

  localparam logic [1:0] PAT_BARS    = 2'd0;
  localparam logic [1:0] PAT_RAMP    = 2'd1;
  localparam logic [1:0] PAT_CHECKER = 2'd2;
  localparam logic [1:0] PAT_FLAT    = 2'd3;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } rgb_t;

  // White, yellow, cyan, green, magenta, red, blue, black (R,G,B).
  localparam logic [23:0] BAR_RGB [8] = '{
    24'hFF_FF_FF,
    24'hFF_FF_00,
    24'h00_FF_FF,
    24'h00_FF_00,
    24'hFF_00_FF,
    24'hFF_00_00,
    24'h00_00_FF,
    24'h00_00_00
  };

  function automatic rgb_t bar_rgb(input logic [2:0] idx);
    return rgb_t'(BAR_RGB[idx]);
  endfunction

  function automatic rgb_t grey(input logic [7:0] v);
    return rgb_t'({v, v, v});
  endfunction

endpackage

// File: rtl/frame_pattern_gen_if.sv
// Pixel stream bundle shared with the downstream frame stages.
interface frame_pattern_gen_if;

  logic [7:0] color_r;
  logic [7:0] color_g;
  logic [7:0] color_b;
  logic       valid;
  logic       start_frame_flag;
  logic       end_frame_flag;

  modport master (
    output color_r,
    output color_g,
    output color_b,
    output valid,
    output start_frame_flag,
    output end_frame_flag
  );

  modport slave (
    input color_r,
    input color_g,
    input color_b,
    input valid,
    input start_frame_flag,
    input end_frame_flag
  );

endinterface

// File: rtl/frame_timing_cnt.sv
// Raster timing: frame FSM with x/y position, colour-bar sub-counter and
// a down-counting blank timer.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// ST_IDLE   | stopped; waits for enable to begin a frame
// ST_ACTIVE | presenting pixel (x, y); x advances each cycle
// ST_HBLANK | horizontal blanking after a line
// ST_VBLANK | vertical blanking after the last line; enable re-sampled at end
module frame_timing_cnt
  import frame_pkg::*;
#(
  parameter int P_H_ACTIVE = 640,
  parameter int P_H_BLANK  = 160,
  parameter int P_V_ACTIVE = 480,
  parameter int P_V_BLANK  = 45
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       enable,
  output logic [7:0] pix_x,        // low byte of the current x
  output logic [7:0] pix_y,        // low byte of the current y
  output logic [2:0] bar_idx,
  output logic       active,
  output logic       frame_start,
  output logic       frame_end,
  output logic       frame_load    // a new frame begins on this edge
);

  localparam int LP_LINE     = P_H_ACTIVE + P_H_BLANK;
  localparam int LP_VB_CYC   = P_V_BLANK * LP_LINE;
  localparam int LP_BLANK_W  = $clog2(LP_VB_CYC + 1);
  localparam int LP_BAR_W    = P_H_ACTIVE / 8;

  frame_state_e          state_q, state_d;
  logic [COORD_W-1:0]    x_q, x_d;
  logic [COORD_W-1:0]    y_q, y_d;
  logic [COORD_W-1:0]    bar_cnt_q, bar_cnt_d;
  logic [2:0]            bar_idx_q, bar_idx_d;
  logic [LP_BLANK_W-1:0] blank_q, blank_d;

  logic last_x, last_y, bar_tc, blank_tc;

  assign last_x   = (x_q == COORD_W'(P_H_ACTIVE - 1));
  assign last_y   = (y_q == COORD_W'(P_V_ACTIVE - 1));
  assign bar_tc   = (bar_cnt_q == COORD_W'(LP_BAR_W - 1));
  assign blank_tc = (blank_q == '0);

  // State and counter registers.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state_q   <= ST_IDLE;
      x_q       <= '0;
      y_q       <= '0;
      bar_cnt_q <= '0;
      bar_idx_q <= '0;
      blank_q   <= '0;
    end else begin
      state_q   <= state_d;
      x_q       <= x_d;
      y_q       <= y_d;
      bar_cnt_q <= bar_cnt_d;
      bar_idx_q <= bar_idx_d;
      blank_q   <= blank_d;
    end
  end

  // Next-state and counter update.
  always_comb begin
    state_d    = state_q;
    x_d        = x_q;
    y_d        = y_q;
    bar_cnt_d  = bar_cnt_q;
    bar_idx_d  = bar_idx_q;
    blank_d    = blank_q;
    frame_load = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (enable) begin
          state_d    = ST_ACTIVE;
          x_d        = '0;
          y_d        = '0;
          bar_cnt_d  = '0;
          bar_idx_d  = '0;
          frame_load = 1'b1;
        end
      end
      ST_ACTIVE: begin
        if (last_x) begin
          state_d   = ST_HBLANK;
          x_d       = '0;
          bar_cnt_d = '0;
          bar_idx_d = '0;
          blank_d   = LP_BLANK_W'(P_H_BLANK - 1);
        end else begin
          x_d = x_q + COORD_W'(1);
          if (bar_tc) begin
            bar_cnt_d = '0;
            bar_idx_d = bar_idx_q + 3'd1;
          end else begin
            bar_cnt_d = bar_cnt_q + COORD_W'(1);
          end
        end
      end
      ST_HBLANK: begin
        if (blank_tc) begin
          if (!last_y) begin
            y_d     = y_q + COORD_W'(1);
            state_d = ST_ACTIVE;
          end else begin
            y_d     = '0;
            state_d = ST_VBLANK;
            blank_d = LP_BLANK_W'(LP_VB_CYC - 1);
          end
        end else begin
          blank_d = blank_q - LP_BLANK_W'(1);
        end
      end
      ST_VBLANK: begin
        if (blank_tc) begin
          if (enable) begin
            state_d    = ST_ACTIVE;
            frame_load = 1'b1;
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          blank_d = blank_q - LP_BLANK_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign active      = (state_q == ST_ACTIVE);
  assign frame_start = active && (x_q == '0) && (y_q == '0);
  assign frame_end   = active && last_x && last_y;
  assign pix_x       = x_q[7:0];
  assign pix_y       = y_q[7:0];
  assign bar_idx     = bar_idx_q;

endmodule

// File: rtl/frame_pattern_gen.sv
// Test-frame source: raster timing plus pattern lookup, with every output
// registered one cycle behind the timing counters.
module frame_pattern_gen
  import frame_pkg::*;
#(
  parameter int P_H_ACTIVE = 640,
  parameter int P_H_BLANK  = 160,
  parameter int P_V_ACTIVE = 480,
  parameter int P_V_BLANK  = 45
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic                i_enable,
  input  logic [1:0]          i_pattern_sel,
  output logic [15:0]         o_frame_cnt,
  frame_pattern_gen_if.master pix
);

  logic [7:0] pix_x, pix_y;
  logic [2:0] bar_idx;
  logic       active, frame_start, frame_end, frame_load;
  logic [1:0] pat_q;
  rgb_t       rgb_d;

  frame_timing_cnt #(
    .P_H_ACTIVE (P_H_ACTIVE),
    .P_H_BLANK  (P_H_BLANK),
    .P_V_ACTIVE (P_V_ACTIVE),
    .P_V_BLANK  (P_V_BLANK)
  ) u_timing (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .enable      (i_enable),
    .pix_x       (pix_x),
    .pix_y       (pix_y),
    .bar_idx     (bar_idx),
    .active      (active),
    .frame_start (frame_start),
    .frame_end   (frame_end),
    .frame_load  (frame_load)
  );

  // Pattern is held for the whole frame, captured as the frame is launched.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      pat_q <= PAT_BARS;
    end else if (frame_load) begin
      pat_q <= i_pattern_sel;
    end
  end

  // Colour of the pixel the timing block is currently pointing at.
  always_comb begin
    rgb_d = '0;
    if (active) begin
      case (pat_q)
        PAT_BARS:    rgb_d = bar_rgb(bar_idx);
        PAT_RAMP:    rgb_d = grey(pix_x);
        PAT_CHECKER: rgb_d = (pix_x[3] ^ pix_y[3]) ? grey(8'hFF) : grey(8'h00);
        default:     rgb_d = grey(8'h80);
      endcase
    end
  end

  // Output registers; flags travel with the colour of the same pixel.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      pix.color_r          <= '0;
      pix.color_g          <= '0;
      pix.color_b          <= '0;
      pix.valid            <= 1'b0;
      pix.start_frame_flag <= 1'b0;
      pix.end_frame_flag   <= 1'b0;
      o_frame_cnt          <= '0;
    end else begin
      pix.color_r          <= rgb_d.r;
      pix.color_g          <= rgb_d.g;
      pix.color_b          <= rgb_d.b;
      pix.valid            <= active;
      pix.start_frame_flag <= frame_start;
      pix.end_frame_flag   <= frame_end;
      if (frame_end) begin
        o_frame_cnt <= o_frame_cnt + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_frame_pattern_gen.sv
// Scoreboard bench for frame_pattern_gen: a small 16x4 instance for timing,
// bars, pattern switching, enable drop and async reset; a 512x12 instance
// for the ramp and checker patterns.
module tb_frame_pattern_gen;

  localparam int A_H = 16, A_HB = 4, A_V = 4, A_VB = 2;
  localparam int A_FRAME = (A_V + A_VB) * (A_H + A_HB);
  localparam int A_S2E   = (A_V - 1) * (A_H + A_HB) + A_H - 1;
  localparam int B_H = 512, B_HB = 4, B_V = 12, B_VB = 1;
  localparam int B_FRAME = (B_V + B_VB) * (B_H + B_HB);
  localparam int B_S2E   = (B_V - 1) * (B_H + B_HB) + B_H - 1;

  logic        clk = 1'b0;
  logic        rst_a, rst_b, en_a, en_b;
  logic [1:0]  sel_a, sel_b;
  logic [15:0] fc_a, fc_b;

  frame_pattern_gen_if a_if ();
  frame_pattern_gen_if b_if ();

  frame_pattern_gen #(
    .P_H_ACTIVE (A_H), .P_H_BLANK (A_HB), .P_V_ACTIVE (A_V), .P_V_BLANK (A_VB)
  ) dut_a (
    .i_clk (clk), .i_rst (rst_a), .i_enable (en_a), .i_pattern_sel (sel_a),
    .o_frame_cnt (fc_a), .pix (a_if)
  );

  frame_pattern_gen #(
    .P_H_ACTIVE (B_H), .P_H_BLANK (B_HB), .P_V_ACTIVE (B_V), .P_V_BLANK (B_VB)
  ) dut_b (
    .i_clk (clk), .i_rst (rst_b), .i_enable (en_b), .i_pattern_sel (sel_b),
    .o_frame_cnt (fc_b), .pix (b_if)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  longint cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference colour of pixel (x, y) for a frame of width h.
  function automatic logic [23:0] exp_rgb(input int pat, input int x, input int y, input int h);
    logic [15:0] xv, yv;
    xv = x[15:0];
    yv = y[15:0];
    case (pat)
      0: begin
        case (x / (h / 8))
          0:       return 24'hFFFFFF;
          1:       return 24'hFFFF00;
          2:       return 24'h00FFFF;
          3:       return 24'h00FF00;
          4:       return 24'hFF00FF;
          5:       return 24'hFF0000;
          6:       return 24'h0000FF;
          default: return 24'h000000;
        endcase
      end
      1:       return {xv[7:0], xv[7:0], xv[7:0]};
      2:       return (xv[3] ^ yv[3]) ? 24'hFFFFFF : 24'h000000;
      default: return 24'h808080;
    endcase
  endfunction

  // Scoreboard entries: {r, g, b, start, end}.
  logic [25:0] q_a[$];
  logic [25:0] q_b[$];

  task automatic push_frame(input int dut, input int pat, input int h, input int v);
    logic [25:0] ent;
    for (int y = 0; y < v; y++) begin
      for (int x = 0; x < h; x++) begin
        ent = {exp_rgb(pat, x, y, h), (x == 0 && y == 0), (x == h - 1 && y == v - 1)};
        if (dut == 0) q_a.push_back(ent);
        else          q_b.push_back(ent);
      end
    end
  endtask

  int     a_starts = 0, a_ends = 0, a_vcnt = 0, a_fc_model = 0;
  int     b_starts = 0, b_ends = 0, b_vcnt = 0, b_fc_model = 0;
  longint a_last_start = -1, b_last_start = -1;
  bit     a_chk_period = 1'b0;

  // Monitor for the small instance.
  always @(negedge clk) begin
    logic [25:0] e;
    if (!rst_a) begin
      q_a.delete();
      a_fc_model = 0;
    end
    if (a_if.valid) begin
      a_vcnt++;
      if (q_a.size() == 0) begin
        chk("a_extra_pixel", 1, 0);
      end else begin
        e = q_a.pop_front();
        chk("a_pix", {a_if.color_r, a_if.color_g, a_if.color_b,
                      a_if.start_frame_flag, a_if.end_frame_flag}, e);
      end
    end else begin
      chk("a_blank", {a_if.color_r, a_if.color_g, a_if.color_b,
                      a_if.start_frame_flag, a_if.end_frame_flag}, 0);
    end
    if (a_if.start_frame_flag) begin
      if (a_chk_period && a_last_start >= 0) chk("a_period", cyc - a_last_start, A_FRAME);
      chk("a_fcnt_at_start", fc_a, a_fc_model);
      a_last_start = cyc;
      a_vcnt = 1;
      a_starts++;
    end
    if (a_if.end_frame_flag) begin
      a_fc_model = (a_fc_model + 1) & 16'hFFFF;
      chk("a_fcnt_at_end", fc_a, a_fc_model);
      chk("a_start_to_end", cyc - a_last_start, A_S2E);
      chk("a_valid_count", a_vcnt, A_H * A_V);
      a_ends++;
    end
  end

  // Monitor for the wide instance.
  always @(negedge clk) begin
    logic [25:0] e;
    if (b_if.valid) begin
      b_vcnt++;
      if (q_b.size() == 0) begin
        chk("b_extra_pixel", 1, 0);
      end else begin
        e = q_b.pop_front();
        chk("b_pix", {b_if.color_r, b_if.color_g, b_if.color_b,
                      b_if.start_frame_flag, b_if.end_frame_flag}, e);
      end
    end else begin
      chk("b_blank", {b_if.color_r, b_if.color_g, b_if.color_b,
                      b_if.start_frame_flag, b_if.end_frame_flag}, 0);
    end
    if (b_if.start_frame_flag) begin
      if (b_last_start >= 0) chk("b_period", cyc - b_last_start, B_FRAME);
      chk("b_fcnt_at_start", fc_b, b_fc_model);
      b_last_start = cyc;
      b_vcnt = 1;
      b_starts++;
    end
    if (b_if.end_frame_flag) begin
      b_fc_model = (b_fc_model + 1) & 16'hFFFF;
      chk("b_fcnt_at_end", fc_b, b_fc_model);
      chk("b_start_to_end", cyc - b_last_start, B_S2E);
      chk("b_valid_count", b_vcnt, B_H * B_V);
      b_ends++;
    end
  end

  function automatic int cnt_of(input int which);
    case (which)
      0:       return a_starts;
      1:       return a_ends;
      2:       return b_starts;
      default: return b_ends;
    endcase
  endfunction

  // Wait for a monitor counter to reach target, within a cycle budget.
  task automatic wait_cnt(input int which, input int target, input int budget, input string tag);
    int n = 0;
    while (cnt_of(which) < target && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (cnt_of(which) < target) chk(tag, cnt_of(which), target);
  endtask

  initial begin
    rst_a = 1'b0; rst_b = 1'b0;
    en_a  = 1'b0; en_b  = 1'b0;
    sel_a = 2'd0; sel_b = 2'd0;
    repeat (3) @(negedge clk);
    chk("a_reset_outputs", {a_if.valid, a_if.color_r, a_if.color_g, a_if.color_b,
                            a_if.start_frame_flag, a_if.end_frame_flag, fc_a}, 0);
    chk("b_reset_outputs", {b_if.valid, b_if.color_r, b_if.color_g, b_if.color_b,
                            b_if.start_frame_flag, b_if.end_frame_flag, fc_b}, 0);
    rst_a = 1'b1; rst_b = 1'b1;
    repeat (2) @(negedge clk);

    // Two bar frames, then flat, then bars again with the select changed mid-frame.
    a_chk_period = 1'b1;
    sel_a = 2'd0;
    en_a  = 1'b1;
    push_frame(0, 0, A_H, A_V);
    push_frame(0, 0, A_H, A_V);
    wait_cnt(0, 2, 300, "a_wait_frame2");
    sel_a = 2'd3;
    push_frame(0, 3, A_H, A_V);
    wait_cnt(0, 3, 200, "a_wait_frame3");
    repeat (30) @(negedge clk);
    sel_a = 2'd0;
    push_frame(0, 0, A_H, A_V);
    wait_cnt(0, 4, 200, "a_wait_frame4");
    repeat (30) @(negedge clk);
    en_a = 1'b0;
    wait_cnt(1, 4, 200, "a_wait_end4");
    repeat (200) @(negedge clk);
    chk("a_idle_no_new_frame", a_starts, 4);
    chk("a_idle_queue_empty", q_a.size(), 0);
    chk("a_idle_frame_cnt", fc_a, 4);

    // Abort a ramp frame mid-line with an asynchronous reset, then restart.
    a_chk_period = 1'b0;
    sel_a = 2'd1;
    en_a  = 1'b1;
    push_frame(0, 1, A_H, A_V);
    wait_cnt(0, 5, 50, "a_wait_frame5");
    repeat (23) @(negedge clk);
    chk("a_pre_reset_valid", a_if.valid, 1);
    @(posedge clk);
    #2 rst_a = 1'b0;
    #1 chk("a_async_reset", {a_if.valid, a_if.color_r, a_if.color_g, a_if.color_b,
                             a_if.start_frame_flag, a_if.end_frame_flag, fc_a}, 0);
    repeat (3) @(negedge clk);
    rst_a = 1'b1;
    push_frame(0, 1, A_H, A_V);
    wait_cnt(0, 6, 20, "a_wait_restart");
    en_a = 1'b0;
    wait_cnt(1, 5, 200, "a_wait_end_restart");
    repeat (50) @(negedge clk);
    chk("a_final_queue_empty", q_a.size(), 0);
    chk("a_final_frame_cnt", fc_a, 1);

    // Wide instance: one ramp frame followed by one checker frame.
    sel_b = 2'd1;
    en_b  = 1'b1;
    push_frame(1, 1, B_H, B_V);
    wait_cnt(2, 1, 50, "b_wait_frame1");
    sel_b = 2'd2;
    push_frame(1, 2, B_H, B_V);
    wait_cnt(2, 2, B_FRAME + 50, "b_wait_frame2");
    en_b = 1'b0;
    wait_cnt(3, 2, B_FRAME + 50, "b_wait_end2");
    repeat (600) @(negedge clk);
    chk("b_final_queue_empty", q_b.size(), 0);
    chk("b_final_frame_cnt", fc_b, 2);
    chk("b_idle_no_new_frame", b_starts, 2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
